// File: rtl/pipe_pkg.sv
// Shared definitions for the EX/MEM pipeline stage: default field widths,
// the EX->MEM bundle layout and the skid-buffer occupancy encoding.
package pipe_pkg;

  localparam int DATA_W     = 32;
  localparam int WB_W       = 2;
  localparam int M_W        = 3;
  localparam int STATUS_W   = 8;
  localparam int REG_ADDR_W = 5;

  // Field order here is the bit order used for the flattened payload.
  typedef struct packed {
    logic [WB_W-1:0]       wb;
    logic [M_W-1:0]        m;
    logic [STATUS_W-1:0]   alu_status;
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     write_data;
    logic [REG_ADDR_W-1:0] rd_addr;
  } ex_mem_bundle_t;

  // Occupancy encoded as {main_valid, skid_valid}; 2'b01 never occurs.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b10,
    SKID_FULL  = 2'b11
  } skid_state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry skid buffer (main + skid register) with flush.
// in_ready comes straight from a flop, so there is no combinational path
// from out_ready back to the producer. Masked payload bits are cleared in
// the main register when it empties (BUBBLE_CLR_MASK) or on flush
// (FLUSH_CLR_MASK); all other payload bits hold.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int               PAY_W           = 8,
  parameter logic [PAY_W-1:0] BUBBLE_CLR_MASK = '0,
  parameter logic [PAY_W-1:0] FLUSH_CLR_MASK  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PAY_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PAY_W-1:0] out_data
);

  skid_state_t      state_reg;
  logic [PAY_W-1:0] main_reg;
  logic [PAY_W-1:0] skid_reg;
  logic             accept;
  logic             drain;

  assign in_ready  = ~state_reg[0];
  assign out_valid = state_reg[1];
  assign out_data  = main_reg;
  assign accept    = in_valid & ~state_reg[0];
  assign drain     = state_reg[1] & out_ready;

  // Occupancy FSM and storage; reset beats flush, flush beats accept/drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= SKID_EMPTY;
      main_reg  <= '0;
      skid_reg  <= '0;
    end else if (flush) begin
      state_reg <= SKID_EMPTY;
      main_reg  <= main_reg & ~FLUSH_CLR_MASK;
    end else begin
      case (state_reg)
        SKID_EMPTY: begin
          if (accept) begin
            main_reg  <= in_data;
            state_reg <= SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (accept && drain) begin
            main_reg <= in_data;
          end else if (drain) begin
            main_reg  <= main_reg & ~BUBBLE_CLR_MASK;
            state_reg <= SKID_EMPTY;
          end else if (accept) begin
            skid_reg  <= in_data;
            state_reg <= SKID_FULL;
          end
        end
        SKID_FULL: begin
          if (drain) begin
            main_reg  <= skid_reg;
            state_reg <= SKID_ONE;
          end
        end
        default: state_reg <= SKID_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/ex_mem_skid_stage.sv
// EX/MEM pipeline stage built on a 2-entry skid buffer.
// WB/M control fields read 0 whenever the stage holds no bundle; a flush
// additionally clears ALU status and destination register while the ALU
// result and store data hold. Reset clears everything.
// Optional macro EX_MEM_PERF_CNT_EN adds stall_cnt / flush_cnt outputs.
module ex_mem_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W     = pipe_pkg::DATA_W,
  parameter int WB_W       = pipe_pkg::WB_W,
  parameter int M_W        = pipe_pkg::M_W,
  parameter int STATUS_W   = pipe_pkg::STATUS_W,
  parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WB_W-1:0]       in_wb,
  input  logic [M_W-1:0]        in_m,
  input  logic [STATUS_W-1:0]   in_alu_status,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic [DATA_W-1:0]     in_write_data,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WB_W-1:0]       out_wb,
  output logic [M_W-1:0]        out_m,
  output logic [STATUS_W-1:0]   out_alu_status,
  output logic [DATA_W-1:0]     out_alu_result,
  output logic [DATA_W-1:0]     out_write_data,
`ifdef EX_MEM_PERF_CNT_EN
  output logic [REG_ADDR_W-1:0] out_rd_addr,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt
`else
  output logic [REG_ADDR_W-1:0] out_rd_addr
`endif
);

  localparam int PAY_W = WB_W + M_W + STATUS_W + 2 * DATA_W + REG_ADDR_W;

  // Payload layout {wb, m, alu_status, alu_result, write_data, rd_addr}.
  localparam logic [PAY_W-1:0] BUBBLE_MASK =
    {{(WB_W + M_W){1'b1}}, {(STATUS_W + 2 * DATA_W + REG_ADDR_W){1'b0}}};
  localparam logic [PAY_W-1:0] FLUSH_MASK =
    {{(WB_W + M_W + STATUS_W){1'b1}}, {(2 * DATA_W){1'b0}}, {REG_ADDR_W{1'b1}}};

  logic [PAY_W-1:0] in_payload;
  logic [PAY_W-1:0] out_payload;

  assign in_payload = {in_wb, in_m, in_alu_status, in_alu_result,
                       in_write_data, in_rd_addr};
  assign {out_wb, out_m, out_alu_status, out_alu_result,
          out_write_data, out_rd_addr} = out_payload;

  pipe_skid_buf #(
    .PAY_W          (PAY_W),
    .BUBBLE_CLR_MASK(BUBBLE_MASK),
    .FLUSH_CLR_MASK (FLUSH_MASK)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_payload),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_payload)
  );

`ifdef EX_MEM_PERF_CNT_EN
  // Count MEM-side stall cycles and flushes that discard a live bundle.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready) stall_cnt <= stall_cnt + 32'd1;
      if (flush && out_valid)      flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Self-checking bench for ex_mem_skid_stage: directed scenarios plus a
// random burst, with a queue scoreboard of accepted bundles.
module tb_ex_mem_skid_stage;
  import pipe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, in_valid, in_ready, out_valid, out_ready;
  ex_mem_bundle_t ib, ob;
  logic [WB_W-1:0]       out_wb;
  logic [M_W-1:0]        out_m;
  logic [STATUS_W-1:0]   out_alu_status;
  logic [DATA_W-1:0]     out_alu_result;
  logic [DATA_W-1:0]     out_write_data;
  logic [REG_ADDR_W-1:0] out_rd_addr;
`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  assign ob = {out_wb, out_m, out_alu_status, out_alu_result, out_write_data, out_rd_addr};

  ex_mem_skid_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_wb(ib.wb), .in_m(ib.m), .in_alu_status(ib.alu_status),
    .in_alu_result(ib.alu_result), .in_write_data(ib.write_data),
    .in_rd_addr(ib.rd_addr),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wb(out_wb), .out_m(out_m), .out_alu_status(out_alu_status),
    .out_alu_result(out_alu_result), .out_write_data(out_write_data),
`ifdef EX_MEM_PERF_CNT_EN
    .out_rd_addr(out_rd_addr),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`else
    .out_rd_addr(out_rd_addr)
`endif
  );

  int checks = 0;
  int errors = 0;
  ex_mem_bundle_t sb_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic ex_mem_bundle_t mk(input logic [31:0] res);
    ex_mem_bundle_t b;
    b.wb         = 2'($urandom_range(1, 3));
    b.m          = 3'($urandom_range(1, 7));
    b.alu_status = 8'($urandom_range(1, 255));
    b.alu_result = res;
    b.write_data = $urandom;
    b.rd_addr    = 5'($urandom_range(1, 31));
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop on drain, push on accept, discard all on reset/flush.
  always @(negedge clk) begin
    if (rst || flush) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        check("sb_nonempty", 128'(sb_q.size() != 0), 128'(1));
        if (sb_q.size() != 0) check("sb_data", 128'(ob), 128'(sb_q.pop_front()));
      end
      if (in_valid && in_ready) sb_q.push_back(ib);
    end
  end

  ex_mem_bundle_t held;

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; ib = mk(32'hDEAD_BEEF);

    // Reset with in_valid held high
    repeat (2) tick();
    check("rst_bundle", 128'(ob), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    rst = 1'b0; in_valid = 1'b0;
    check("rst_in_ready", 128'(in_ready), 128'(1));

    // Streaming, 1-cycle latency
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ib = mk(32'((i + 1) * 16)); in_valid = 1'b1;
      tick();
      check("stream_in_ready", 128'(in_ready), 128'(1));
      check("stream_valid", 128'(out_valid), 128'(1));
      check("stream_result", 128'(out_alu_result), 128'((i + 1) * 16));
    end
    in_valid = 1'b0;
    tick();
    check("bubble_valid", 128'(out_valid), 128'(0));
    check("bubble_wb_m", 128'({out_wb, out_m}), 128'(0));
    check("bubble_result_hold", 128'(out_alu_result), 128'(32'h40));

    // Backpressure
    out_ready = 1'b0;
    ib = mk(32'hA1); held = ib; in_valid = 1'b1;
    tick();
    check("bp_ready_one", 128'(in_ready), 128'(1));
    ib = mk(32'hA2);
    tick();
    check("bp_ready_full", 128'(in_ready), 128'(0));
    check("bp_out_a1", 128'(out_alu_result), 128'(32'hA1));
    in_valid = 1'b0;
    tick();
    check("bp_hold", 128'(ob), 128'(held));
    out_ready = 1'b1;
    tick();
    check("bp_drain_a2", 128'(out_alu_result), 128'(32'hA2));
    check("bp_ready_back", 128'(in_ready), 128'(1));
    tick();
    check("bp_empty", 128'(out_valid), 128'(0));

    // Flush while FULL with an incoming bundle
    out_ready = 1'b0;
    ib = mk(32'hB1); held = ib; in_valid = 1'b1;
    tick();
    ib = mk(32'hB2);
    tick();
    ib = mk(32'hC0); ib.wb = 2'b11; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_valid", 128'(out_valid), 128'(0));
    check("fl_ctrl", 128'({out_wb, out_m, out_alu_status, out_rd_addr}), 128'(0));
    check("fl_data_hold", 128'({out_alu_result, out_write_data}),
          128'({held.alu_result, held.write_data}));
    check("fl_in_ready", 128'(in_ready), 128'(1));
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fl_no_ghost", 128'(out_valid), 128'(0));
    end

    // Random burst, then bounded drain
    for (int i = 0; i < 60; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      ib        = mk($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && out_valid; i++) tick();
    check("rnd_drained", 128'(out_valid), 128'(0));
    check("rnd_sb_empty", 128'(sb_q.size()), 128'(0));

    // Reset and flush together while FULL
    out_ready = 1'b0;
    ib = mk(32'hD1); in_valid = 1'b1;
    tick();
    ib = mk(32'hD2);
    tick();
    rst = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    check("rf_bundle", 128'(ob), 128'(0));
    check("rf_valid", 128'(out_valid), 128'(0));
    check("rf_in_ready", 128'(in_ready), 128'(1));

`ifdef EX_MEM_PERF_CNT_EN
    check("perf_rst", 128'({stall_cnt, flush_cnt}), 128'(0));
    ib = mk(32'hE1); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check("perf_stall5", 128'(stall_cnt), 128'(5));
    out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    check("perf_stall_after", 128'(stall_cnt), 128'(5));
    check("perf_flush1", 128'(flush_cnt), 128'(1));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
